// File: rtl/cluster_feeder.sv
// Streams pixel/weight pairs from local memories in lockstep, with a static bias word, one pass per start.
// First beat is valid 2 cycles after start; a beat advances only when both x and w handshake together.
module cluster_feeder #(
  parameter int INPUT_SIZE = 784,
  parameter int ADDR_W     = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_en,
  input  logic [1:0]        ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [63:0]       ld_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [11:0]       x_tdata,
  output logic              x_tvalid,
  input  logic              x_tready,
  output logic [63:0]       w_tdata,
  output logic              w_tvalid,
  input  logic              w_tready,
  output logic [63:0]       b_tdata,
  output logic              b_tvalid,
  input  logic              b_tready
);

  localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_STREAM, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic [11:0]      x_dat_q, x_dat_d;
  logic [63:0]      w_dat_q, w_dat_d;
  logic [63:0]      bias_q;

  logic [11:0]      pix_mem [INPUT_SIZE];
  logic [63:0]      wt_mem  [INPUT_SIZE];

  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             idle, ld_in_range, fire, lone, last;
  logic             unused_b_tready;

  assign unused_b_tready = b_tready;

  assign idle        = (state_q == S_IDLE);
  assign ld_in_range = (32'(ld_addr) < INPUT_SIZE);
  assign fire        = x_tvalid & x_tready & w_tvalid & w_tready;
  assign lone        = (x_tvalid & x_tready) ^ (w_tvalid & w_tready);
  assign last        = (idx_q == IDX_W'(INPUT_SIZE - 1));

  // Memories and bias have no reset so their contents survive an aborted pass.
  always_ff @(posedge CLK) begin
    if (ld_en && idle && ld_in_range && ld_sel == 2'd0) pix_mem[ld_addr[IDX_W-1:0]] <= ld_data[11:0];
    if (ld_en && idle && ld_in_range && ld_sel == 2'd1) wt_mem[ld_addr[IDX_W-1:0]]  <= ld_data;
    if (ld_en && idle && ld_sel == 2'd2)                bias_q <= ld_data;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    x_dat_d = x_dat_q;
    w_dat_d = w_dat_q;
    rd_en   = 1'b0;
    rd_idx  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PREFETCH;
          err_d   = 1'b0;
        end
      end
      S_PREFETCH: begin
        rd_en   = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (fire) begin
          if (last) begin
            state_d = S_FINISH;
            idx_d   = '0;
            x_dat_d = '0;
            w_dat_d = '0;
          end else begin
            // Fetch the next index in the firing cycle to keep back-to-back beats.
            idx_d  = idx_q + 1'b1;
            rd_en  = 1'b1;
            rd_idx = idx_q + 1'b1;
          end
        end else if (lone) begin
          err_d = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (rd_en) begin
      x_dat_d = pix_mem[rd_idx];
      w_dat_d = wt_mem[rd_idx];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      x_dat_q <= '0;
      w_dat_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      x_dat_q <= x_dat_d;
      w_dat_q <= w_dat_d;
    end
  end

  assign busy     = !idle;
  assign done     = (state_q == S_FINISH);
  assign err      = err_q;
  assign x_tvalid = (state_q == S_STREAM);
  assign w_tvalid = (state_q == S_STREAM);
  assign x_tdata  = x_dat_q;
  assign w_tdata  = w_dat_q;
  assign b_tvalid = busy;
  assign b_tdata  = busy ? bias_q : '0;

endmodule

// File: tb/tb_cluster_feeder.sv
// Randomized scoreboard bench for cluster_feeder with INPUT_SIZE=4.
module tb_cluster_feeder;
  localparam int N  = 4;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ld_en = 1'b0;
  logic [1:0]    ld_sel = '0;
  logic [AW-1:0] ld_addr = '0;
  logic [63:0]   ld_data = '0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic [11:0]   x_tdata;
  logic          x_tvalid;
  logic          x_tready = 1'b1;
  logic [63:0]   w_tdata;
  logic          w_tvalid;
  logic          w_tready = 1'b1;
  logic [63:0]   b_tdata;
  logic          b_tvalid;
  logic          b_tready = 1'b1;

  cluster_feeder #(.INPUT_SIZE(N), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .busy(busy), .done(done), .err(err),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
    .w_tdata(w_tdata), .w_tvalid(w_tvalid), .w_tready(w_tready),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] x;
    logic [63:0] w;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] pix_m [N];
  logic [63:0] wt_m  [N];
  logic [63:0] bias_m = '0;
  beat_t       exp_q [$];
  bit          pass_active = 0;
  bit          err_exp = 0;
  bit          first_seen = 1;
  bit          prev_hold = 0;
  logic [11:0] prev_x;
  logic [63:0] prev_w;
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_fire_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          beats_fired = 0;
  int          rdy_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(posedge CLK) cyc++;

  // Ready randomizer; mode 0 leaves the readies to the directed sequences.
  always @(posedge CLK) begin
    logic r;
    #1;
    if (rdy_mode == 1) begin
      r = ($urandom_range(0, 3) != 0);
      x_tready = r;
      w_tready = r;
    end else if (rdy_mode == 2) begin
      x_tready = ($urandom_range(0, 3) != 0);
      w_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor and reference model: decides acceptance of loads and starts from
  // the bench's own view of whether a pass is in flight.
  always @(negedge CLK) begin
    beat_t      b;
    logic       xf, wf;
    logic [1:0] ai;
    if (!RST) begin
      chk("rst_flags", 64'({busy, done, err}), 64'(0));
      chk("rst_valids", 64'({x_tvalid, w_tvalid, b_tvalid}), 64'(0));
      chk("rst_x_tdata", 64'(x_tdata), 64'(0));
      chk("rst_w_tdata", w_tdata, 64'(0));
      chk("rst_b_tdata", b_tdata, 64'(0));
      exp_q.delete();
      pass_active = 0;
      err_exp     = 0;
      prev_hold   = 0;
      first_seen  = 1;
    end else begin
      chk("err", 64'(err), 64'(err_exp));
      chk("busy", 64'(busy), 64'(pass_active));
      chk("lockstep_valid", 64'(x_tvalid), 64'(w_tvalid));
      if (pass_active) begin
        chk("b_tvalid", 64'(b_tvalid), 64'(1));
        chk("b_tdata", b_tdata, bias_m);
      end else begin
        chk("idle_ctrl", 64'({b_tvalid, x_tvalid, done}), 64'(0));
        chk("idle_b_tdata", b_tdata, 64'(0));
        chk("idle_x_tdata", 64'(x_tdata), 64'(0));
        chk("idle_w_tdata", w_tdata, 64'(0));
      end
      if (prev_hold) begin
        chk("hold_valid", 64'(x_tvalid), 64'(1));
        chk("hold_x", 64'(x_tdata), 64'(prev_x));
        chk("hold_w", w_tdata, prev_w);
      end
      if (x_tvalid && !first_seen) begin
        chk("first_valid_latency", 64'(cyc), 64'(start_cyc + 2));
        first_seen = 1;
      end
      xf = x_tvalid && x_tready;
      wf = w_tvalid && w_tready;
      if (xf && wf) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected actual=%0h/%0h expected=none", x_tdata, w_tdata);
        end else begin
          b = exp_q.pop_front();
          chk("beat_x", 64'(x_tdata), 64'(b.x));
          chk("beat_w", w_tdata, b.w);
        end
        beats_fired++;
        last_fire_cyc = cyc;
      end else if (xf || wf) begin
        err_exp = 1;
      end
      prev_hold = x_tvalid && !(xf && wf);
      prev_x    = x_tdata;
      prev_w    = w_tdata;
      if (ld_en && !pass_active) begin
        ai = ld_addr[1:0];
        if (ld_sel == 2'd0 && ld_addr < N) pix_m[ai] = ld_data[11:0];
        if (ld_sel == 2'd1 && ld_addr < N) wt_m[ai]  = ld_data;
        if (ld_sel == 2'd2) bias_m = ld_data;
      end
      if (done) begin
        chk("done_in_pass", 64'(pass_active), 64'(1));
        chk("done_all_beats", 64'(exp_q.size()), 64'(0));
        chk("done_after_last", 64'(cyc), 64'(last_fire_cyc + 1));
        done_cnt++;
        done_cyc = cyc;
      end
      if (start && !pass_active) begin
        for (int k = 0; k < N; k++) exp_q.push_back('{pix_m[k], wt_m[k]});
        pass_active = 1;
        start_cyc   = cyc;
        first_seen  = 0;
        beats_fired = 0;
        err_exp     = 0;
      end else if (done) begin
        pass_active = 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [1:0] s, input logic [AW-1:0] a, input logic [63:0] d);
    tick();
    ld_en = 1'b1; ld_sel = s; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge CLK); #1; n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL wait_done timeout actual=no_done expected=done within %0d cycles", budget);
    end
  endtask

  task automatic wait_beats(input int k, input int budget);
    int n = 0;
    while (beats_fired < k && n < budget) begin
      @(negedge CLK); #1; n++;
    end
    checks++;
    if (beats_fired < k) begin
      errors++;
      $display("FAIL wait_beats timeout actual=%0d expected=%0d", beats_fired, k);
    end
  endtask

  initial begin
    int d0;
    #1 RST = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    repeat (2) tick();

    // Directed load, plus a reserved-target and an out-of-range write.
    for (int k = 0; k < N; k++) begin
      do_load(2'd0, AW'(k), 64'(k + 1));
      do_load(2'd1, AW'(k), 64'((k + 1) * 17));
    end
    do_load(2'd2, '0, 64'hABCD);
    do_load(2'd3, '0, 64'hDEAD);
    do_load(2'd0, AW'(5), 64'h777);

    // Full-rate pass: beats on consecutive cycles, done right after the last.
    pulse_start();
    wait_done(50);
    chk("full_rate_done_cycle", 64'(done_cyc), 64'(start_cyc + 2 + N));

    // Both readies stall on beat 1 for three cycles.
    pulse_start();
    wait_beats(1, 50);
    tick(); x_tready = 1'b0; w_tready = 1'b0;
    tick(); tick(); tick();
    x_tready = 1'b1; w_tready = 1'b1;
    wait_done(50);

    // Lone x handshake on beat 2 sets the sticky error.
    pulse_start();
    wait_beats(2, 50);
    tick(); w_tready = 1'b0;
    tick(); w_tready = 1'b1;
    wait_done(50);
    tick();
    chk("err_sticky", 64'(err), 64'(1));

    // Reset mid-pass during beat 2, then replay from index 0.
    pulse_start();
    wait_beats(2, 50);
    d0 = done_cnt;
    @(posedge CLK); #2;
    RST = 1'b0;
    #1;
    chk("async_rst_valids", 64'({x_tvalid, w_tvalid, busy, b_tvalid}), 64'(0));
    tick(); tick();
    @(posedge CLK); #2;
    RST = 1'b1;
    repeat (4) tick();
    chk("no_done_after_abort", 64'(done_cnt), 64'(d0));
    pulse_start();
    wait_done(50);

    // Loads and starts while busy are dropped.
    d0 = done_cnt;
    pulse_start();
    do_load(2'd0, '0, 64'hFFF);
    pulse_start();
    wait_done(50);
    repeat (6) tick();
    chk("single_done", 64'(done_cnt), 64'(d0 + 1));
    pulse_start();
    wait_done(50);

    // Randomized loads and backpressure.
    for (int it = 0; it < 25; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 4)); j++)
        do_load(2'($urandom_range(0, 3)), AW'($urandom_range(0, 5)), {$urandom, $urandom});
      rdy_mode = int'($urandom_range(0, 2));
      pulse_start();
      if ($urandom_range(0, 3) == 0) pulse_start();
      wait_done(300);
      rdy_mode = 0;
      x_tready = 1'b1; w_tready = 1'b1;
      tick();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
